// File: rtl/drum_pkg.sv
// drum_pkg: shared state encoding and sizing for the drum step sequencer.
package drum_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;
  localparam int STEPS = 16;
  localparam int TRACKS = 4;
  localparam int DEFAULT_MAX_BPM = 300;
endpackage

// File: rtl/step_timer.sv
// step_timer: phase accumulator that fires once per 16th note at the clamped tempo.
module step_timer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [13:0] tempo_c,
  output logic        fire
);
  // Four 16ths per beat and 60 s per minute: fire when acc reaches CLK_HZ*60/4.
  localparam logic [31:0] THRESH = 32'(CLK_HZ * 15);
  logic [30:0] acc_q, acc_d;
  logic [31:0] sum, diff;
  always_comb begin
    sum = {1'b0, acc_q} + {18'd0, tempo_c};
    diff = sum - THRESH;
    fire = en && sum >= THRESH;
    acc_d = clr ? '0 : fire ? diff[30:0] : en ? sum[30:0] : acc_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/step_scheduler.sv
// step_scheduler: transport FSM, 16-step counter and 4-track pattern lookup.
module step_scheduler import drum_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int MAX_BPM = DEFAULT_MAX_BPM
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] tempo,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [63:0] pattern,
  output logic [3:0]  step,
  output logic        step_pulse,
  output logic [3:0]  trig,
  output logic        beat_pulse,
  output logic        bar_pulse,
  output logic [1:0]  state
);
  state_e state_q, state_d;
  logic [3:0] step_q, step_d, trig_q, trig_d;
  logic pulse_q, pulse_d, beat_q, beat_d, bar_q, bar_d;
  logic [13:0] tempo_c;
  logic go, en, clr, fire;
  step_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .tempo_c(tempo_c), .fire(fire)
  );
  always_comb begin
    tempo_c = (tempo > 14'(MAX_BPM)) ? 14'(MAX_BPM) : tempo;
    go = start && !stop && state_q == IDLE;
    state_d = stop ? IDLE : (pause && state_q == RUN) ? PAUSE : (start && state_q != RUN) ? RUN : state_q;
    // Accumulate only in cycles that stay in RUN, so pause and stop never emit a step.
    en = state_q == RUN && !stop && !pause;
    clr = stop || go;
    pulse_d = go || fire;
    step_d = clr ? '0 : fire ? step_q + 4'd1 : step_q;
    trig_d = '0;
    for (int t = 0; t < TRACKS; t++) trig_d[t] = pulse_d && pattern[{2'(t), step_d}];
    beat_d = pulse_d && step_d[1:0] == 2'd0;
    bar_d = pulse_d && step_d == 4'd0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q <= '0;
      trig_q <= '0;
      pulse_q <= 1'b0;
      beat_q <= 1'b0;
      bar_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      trig_q <= trig_d;
      pulse_q <= pulse_d;
      beat_q <= beat_d;
      bar_q <= bar_d;
    end
  end
  assign step = step_q;
  assign step_pulse = pulse_q;
  assign trig = trig_q;
  assign beat_pulse = beat_q;
  assign bar_pulse = bar_q;
  assign state = state_q;
endmodule
